// File: rtl/sync_fifo_pkg.sv
// Shared constants and sizing helper for the synchronous FIFO.
// The top-level module and the storage sub-module both import this package.
package sync_fifo_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 16;

  // Pointers and the occupancy count both need one bit beyond the address,
  // so that a completely full FIFO can be distinguished from an empty one.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH register-array storage for the FIFO.
// It has one synchronous write port and one asynchronous read port.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the storage array has no reset; only the pointers define which entries are valid, and leaving it out keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered status flags and overflow/underflow pulses.
// FWFT selects either a registered read port or a first-word-fall-through read port.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic                        rd_en,
  output logic [WIDTH-1:0]            rd_data,
  output logic                        flag_full,
  output logic                        flag_empty,
  output logic                        flag_almost_full,
  output logic                        flag_almost_empty,
  output logic [ptr_width(DEPTH)-1:0] count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_C    = PW'(AE_THRESH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             afull_q, afull_d, aempty_q, aempty_d;
  logic             overflow_q, overflow_d, underflow_q, underflow_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d, mem_rdata;
  logic             rd_accept, wr_accept;

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign rd_accept = rd_en && !empty_q;
  assign wr_accept = wr_en && (!full_q || rd_accept);

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_accept && !rst),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    wr_ptr_d = wr_accept ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = rd_accept ? rd_ptr_q + PW'(1) : rd_ptr_q;

    count_d = count_q;
    if (wr_accept && !rd_accept) begin
      count_d = count_q + PW'(1);
    end else if (rd_accept && !wr_accept) begin
      count_d = count_q - PW'(1);
    end

    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AF_C);
    aempty_d = (count_d <= AE_C);

    overflow_d  = wr_en && !wr_accept;
    underflow_d = rd_en && !rd_accept;

    rd_data_d = rd_data_q;
    if (FWFT == 0 && rd_accept) begin
      rd_data_d = mem_rdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so that every register samples its pre-edge inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      afull_q     <= afull_d;
      aempty_q    <= aempty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // In FWFT mode the head word is presented directly; when the FIFO is empty the output is driven to zero.
  assign rd_data           = (FWFT != 0) ? (empty_q ? '0 : mem_rdata) : rd_data_q;
  assign flag_full         = full_q;
  assign flag_empty        = empty_q;
  assign flag_almost_full  = afull_q;
  assign flag_almost_empty = aempty_q;
  assign count             = count_q;
  assign overflow          = overflow_q;
  assign underflow         = underflow_q;

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, legal range 1..256.
REQ-002 Parameter DEPTH, default 16: number of entries; SHALL be a power of two, >= 2.
REQ-003 Parameter AF_THRESH, default DEPTH-2: flag_almost_full asserts when count >= AF_THRESH.
REQ-004 Parameter AE_THRESH, default 2: flag_almost_empty asserts when count <= AE_THRESH.
REQ-005 Parameter FWFT, default 0: 0 = registered read (1-cycle latency); 1 = first-word-fall-through.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 wr_en  input  1  write request.
REQ-009 wr_data  input  WIDTH  write word, sampled with wr_en.
REQ-010 rd_en  input  1  read (pop) request.
REQ-011 rd_data  output  WIDTH  read word.
REQ-012 flag_full  output  1  count == DEPTH.
REQ-013 flag_empty  output  1  count == 0.
REQ-014 flag_almost_full  output  1  count >= AF_THRESH.
REQ-015 flag_almost_empty  output  1  count <= AE_THRESH.
REQ-016 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-017 overflow  output  1  one-cycle pulse: write rejected.
REQ-018 underflow  output  1  one-cycle pulse: read rejected.

Function
REQ-019 Write accepted iff wr_en && (!flag_full || rd_en accepted same cycle); word stored at wr_ptr, wr_ptr increments.
REQ-020 Read accepted iff rd_en && !flag_empty; rd_ptr increments.
REQ-021 Empty + wr_en + rd_en in same cycle: write accepted, read rejected, underflow pulses next cycle, count becomes 1.
REQ-022 Full + wr_en + rd_en in same cycle: both accepted, count stays DEPTH, flag_full stays high.
REQ-023 Pointers $clog2(DEPTH)+1 bits; MSB is wrap bit; address = low bits; wrap from DEPTH-1 to 0 without stall.
REQ-024 count updates next cycle: +1 write-only, -1 read-only, unchanged both/neither.
REQ-025 All flags registered, derived from next-state count, valid the same cycle as count.
REQ-026 FWFT=0: rd_data loads mem[rd_ptr] on the edge where a read is accepted, valid the following cycle; holds otherwise.
REQ-027 FWFT=1: rd_data = mem[rd_ptr] whenever !flag_empty; rd_en pops; first written word visible one cycle after its write.
REQ-028 overflow = registered (wr_en && !write accepted); underflow = registered (rd_en && !read accepted).
REQ-029 Data read out SHALL equal data written, in order, with no loss or duplication.

Reset
REQ-030 rst high at rising edge: wr_ptr, rd_ptr, count = 0; flag_empty = 1; flag_almost_empty = 1; flag_full, flag_almost_full, overflow, underflow = 0; rd_data = 0.
REQ-031 Reset mid-operation discards all contents; wr_en/rd_en ignored while rst high; storage array not cleared.

Structure
REQ-032 Package sync_fifo_pkg holds default WIDTH/DEPTH constants and a function computing pointer/count width.
REQ-033 Sub-module sync_fifo_mem: DEPTH x WIDTH register array, one write port, one asynchronous read port.
REQ-034 Pointer, count, flag and read-register logic reside in sync_fifo.

Verification (WIDTH=8, DEPTH=8, AF_THRESH=6, AE_THRESH=2)
REQ-035 Write 0x01..0x08 -> flag_full=1 after 8th write, count=8, flag_almost_full=1 from count 6; 9th write 0xFF -> overflow pulse, contents unchanged.
REQ-036 Drain full FIFO, FWFT=0 -> rd_data 0x01..0x08 each one cycle after rd_en; flag_empty=1 after 8th read; extra rd_en -> underflow pulse.
REQ-037 Full FIFO, wr_en+rd_en with 0xAA -> count stays 8, read returns 0x01, 0xAA appears after 0x08.
REQ-038 Empty FIFO, wr_en(0x55)+rd_en same cycle -> underflow pulse, count=1, next read returns 0x55.
REQ-039 FWFT=1, write 0x3C -> rd_data=0x3C one cycle later without rd_en; 20 interleaved writes/reads wrap pointers, order preserved.
REQ-040 rst at count=5 -> next cycle count=0, flag_empty=1, flag_almost_empty=1, subsequent write/read returns new data only.
